subneg_seq: RTL and testbench

Fetch/execute sequencer for the SUBNEG one-instruction core in `tt_um_macros77_subneg`. Each instruction is three consecutive bytes `a, b, c`. The sequencer runs `mem[b] <= mem[b] - mem[a]`, then branches to `c` if the result is negative, otherwise falls through to `pc + 3`. It drives a single shared byte-wide memory port through a req/ack handshake and sits between the top-level pin mux and the operand memory/loader.

---
 rtl/subneg_seq_if.sv | 23 ++
 rtl/subneg_seq.sv | 160 ++++++++++++++++
 tb/tb_subneg_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/subneg_seq_if.sv
// subneg_seq_if: byte-wide req/ack memory port for the SUBNEG sequencer.
// master = sequencer side, slave = memory/loader side.
interface subneg_seq_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/subneg_seq.sv
// subneg_seq: fetch/execute sequencer, mem[b] -= mem[a], branch to c if negative.
// Optional SUBNEG_STEP_EN adds a PAUSE state after each instruction (single-step).
module subneg_seq #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              run,
   input  logic [ADDR_W-1:0] pc_init,
   subneg_seq_if.master      bus,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] result,
   output logic              busy,
   output logic              halted
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FA,
      S_FB,
      S_FC,
      S_RA,
      S_RB,
      S_EX,
      S_WR,
`ifdef SUBNEG_STEP_EN
      S_PAUSE,
`endif
      S_HALT
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] a_q, b_q, c_q;
   logic [DATA_W-1:0] opa_q, opb_q;
   logic [DATA_W-1:0] d;
   logic              neg;
   logic              start;
   logic              self_loop;

   assign d         = opb_q - opa_q;
   assign neg       = d[DATA_W-1];
   assign start     = run && ena;
   assign self_loop = neg && (c_q == pc);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next state and memory port drive; access states advance only on ack
   always_comb begin
      state_d       = state_q;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      busy          = 1'b1;
      halted        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_FA;
         end
         S_FA: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = pc;
            if (bus.mem_ack) state_d = S_FB;
         end
         S_FB: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = pc + ADDR_W'(1);
            if (bus.mem_ack) state_d = S_FC;
         end
         S_FC: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = pc + ADDR_W'(2);
            if (bus.mem_ack) state_d = S_RA;
         end
         S_RA: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = a_q;
            if (bus.mem_ack) state_d = S_RB;
         end
         S_RB: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = b_q;
            if (bus.mem_ack) state_d = S_EX;
         end
         S_EX: begin
            if (ena) state_d = S_WR;
         end
         S_WR: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = b_q;
            bus.mem_wdata = d;
            if (bus.mem_ack) begin
               if (self_loop) state_d = S_HALT;
`ifdef SUBNEG_STEP_EN
               else           state_d = S_PAUSE;
`else
               else           state_d = S_FA;
`endif
            end
         end
`ifdef SUBNEG_STEP_EN
         S_PAUSE: begin
            busy = 1'b0;
            if (start) state_d = S_FA;
         end
`endif
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
            if (start) state_d = S_FA;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // operand latches, pc and result; all captured on the ack edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '0;
         opa_q  <= '0;
         opb_q  <= '0;
         pc     <= '0;
         result <= '0;
      end else begin
         if ((state_q == S_IDLE || state_q == S_HALT) && start)
            pc <= pc_init;
         if (bus.mem_ack) begin
            unique case (state_q)
               S_FA: a_q   <= ADDR_W'(bus.mem_rdata);
               S_FB: b_q   <= ADDR_W'(bus.mem_rdata);
               S_FC: c_q   <= ADDR_W'(bus.mem_rdata);
               S_RA: opa_q <= bus.mem_rdata;
               S_RB: opb_q <= bus.mem_rdata;
               S_WR: begin
                  result <= d;
                  if (!neg)
                     pc <= pc + ADDR_W'(3);
                  else if (!self_loop)
                     pc <= c_q;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_subneg_seq.sv
// tb_subneg_seq: directed bench with a memory model and an access scoreboard.
// Build with +define+SUBNEG_STEP_EN to cover the single-step variant.
module tb_subneg_seq;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       run;
   logic [7:0] pc_init;
   logic [7:0] pc;
   logic [7:0] result;
   logic       busy;
   logic       halted;

   subneg_seq_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   subneg_seq #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .run     (run),
      .pc_init (pc_init),
      .bus     (bus),
      .pc      (pc),
      .result  (result),
      .busy    (busy),
      .halted  (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } acc_t;

   acc_t       q[$];
   logic [7:0] mem [256];
   int         n_chk  = 0;
   int         n_pass = 0;
   int         dly    = 0;
   int         wcnt   = 0;
   bit         pend   = 0;
   logic       h_we;
   logic [7:0] h_addr;
   logic [7:0] h_wd;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic push(input logic we, input logic [7:0] a,
                       input logic [7:0] dt);
      acc_t e;
      e.we   = we;
      e.addr = a;
      e.data = we ? dt : 8'h00;
      q.push_back(e);
   endtask

   task automatic clr_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   // one clock of memory behaviour; entered and left at posedge+1
   task automatic step(output bit wr_done);
      acc_t e;
      acc_t g;
      wr_done       = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      if (bus.mem_req) begin
         if (!pend) begin
            pend   = 1'b1;
            wcnt   = 0;
            h_we   = bus.mem_we;
            h_addr = bus.mem_addr;
            h_wd   = bus.mem_wdata;
         end else begin
            chk("stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                {h_we, h_addr, h_wd});
         end
         if (wcnt >= dly) begin
            bus.mem_ack = 1'b1;
            pend        = 1'b0;
            g.we   = bus.mem_we;
            g.addr = bus.mem_addr;
            g.data = bus.mem_we ? bus.mem_wdata : 8'h00;
            if (bus.mem_we) begin
               mem[bus.mem_addr] = bus.mem_wdata;
               wr_done = 1'b1;
            end else begin
               bus.mem_rdata = mem[bus.mem_addr];
            end
            if (q.size() == 0) begin
               chk("sb_extra", 32'(q.size()), 32'd1);
            end else begin
               e = q.pop_front();
               chk("access", 32'(g), 32'(e));
            end
         end else begin
            wcnt++;
         end
      end else begin
         pend = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit w;
      for (int i = 0; i < n; i++) step(w);
   endtask

   task automatic run_start(input logic [7:0] init);
      bit w;
      pc_init = init;
      run     = 1'b1;
      step(w);
      run     = 1'b0;
   endtask

   task automatic exec(output int n);
      bit w;
      n = 0;
      w = 1'b0;
      while (!w && n < 300) begin
         step(w);
         n++;
      end
      chk("wr_seen", {31'b0, w}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      run           = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      #2;
      rst_n = 1'b1;
      q.delete();
      pend = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int k;
      bit w;

      rst_n         = 1'b0;
      ena           = 1'b0;
      run           = 1'b0;
      pc_init       = 8'h00;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      clr_mem();

      // reset with random inputs
      for (int i = 0; i < 4; i++) begin
         run           = 1'($urandom);
         ena           = 1'($urandom);
         pc_init       = 8'($urandom);
         bus.mem_ack   = 1'($urandom);
         bus.mem_rdata = 8'($urandom);
         @(posedge clk);
         #1;
      end
      chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
      chk("rst_we", {31'b0, bus.mem_we}, 32'd0);
      chk("rst_addr", {24'b0, bus.mem_addr}, 32'd0);
      chk("rst_wdata", {24'b0, bus.mem_wdata}, 32'd0);
      chk("rst_pc", {24'b0, pc}, 32'd0);
      chk("rst_result", {24'b0, result}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);

      run           = 1'b0;
      ena           = 1'b1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      rst_n         = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(w);
         chk("idle_req", {31'b0, bus.mem_req}, 32'd0);
         chk("idle_busy", {31'b0, busy}, 32'd0);
      end

      // run without ena must not start
      ena     = 1'b0;
      pc_init = 8'h00;
      run     = 1'b1;
      step(w);
      run     = 1'b0;
      ena     = 1'b1;
      chk("noena_busy", {31'b0, busy}, 32'd0);
      chk("noena_req", {31'b0, bus.mem_req}, 32'd0);

      // fall-through
      clr_mem();
      mem[8'h00] = 8'h08;
      mem[8'h01] = 8'h09;
      mem[8'h02] = 8'h20;
      mem[8'h08] = 8'h03;
      mem[8'h09] = 8'h0A;
      dly = 0;
      push(0, 8'h00, 0);
      push(0, 8'h01, 0);
      push(0, 8'h02, 0);
      push(0, 8'h08, 0);
      push(0, 8'h09, 0);
      push(1, 8'h09, 8'h07);
      run_start(8'h00);
      exec(n);
      chk("ft_cycles", 32'(n), 32'd7);
      chk("ft_result", {24'b0, result}, 32'h07);
      chk("ft_pc", {24'b0, pc}, 32'h03);
      chk("ft_halted", {31'b0, halted}, 32'd0);
      chk("ft_mem9", {24'b0, mem[8'h09]}, 32'h07);
      chk("ft_sb_left", 32'(q.size()), 32'd0);
`ifdef SUBNEG_STEP_EN
      chk("pause_busy", {31'b0, busy}, 32'd0);
      chk("pause_req", {31'b0, bus.mem_req}, 32'd0);
      chk("pause_halted", {31'b0, halted}, 32'd0);
      idle(2);
      chk("pause_hold", {31'b0, bus.mem_req}, 32'd0);
      run_start(8'h55);
      chk("step_req", {31'b0, bus.mem_req}, 32'd1);
      chk("step_addr", {24'b0, bus.mem_addr}, 32'h03);
`else
      chk("next_fa_req", {31'b0, bus.mem_req}, 32'd1);
      chk("next_fa_addr", {24'b0, bus.mem_addr}, 32'h03);
`endif
      do_reset();

      // branch
      clr_mem();
      mem[8'h00] = 8'h08;
      mem[8'h01] = 8'h09;
      mem[8'h02] = 8'h20;
      mem[8'h08] = 8'h0A;
      mem[8'h09] = 8'h03;
      push(0, 8'h00, 0);
      push(0, 8'h01, 0);
      push(0, 8'h02, 0);
      push(0, 8'h08, 0);
      push(0, 8'h09, 0);
      push(1, 8'h09, 8'hF9);
      run_start(8'h00);
      exec(n);
      chk("br_cycles", 32'(n), 32'd7);
      chk("br_result", {24'b0, result}, 32'hF9);
      chk("br_pc", {24'b0, pc}, 32'h20);
      chk("br_halted", {31'b0, halted}, 32'd0);
      chk("br_sb_left", 32'(q.size()), 32'd0);
`ifndef SUBNEG_STEP_EN
      chk("br_fa_addr", {24'b0, bus.mem_addr}, 32'h20);
`endif
      do_reset();

      // self-loop halt, then restart
      clr_mem();
      mem[8'h20] = 8'h08;
      mem[8'h21] = 8'h09;
      mem[8'h22] = 8'h20;
      mem[8'h08] = 8'h01;
      mem[8'h09] = 8'h00;
      push(0, 8'h20, 0);
      push(0, 8'h21, 0);
      push(0, 8'h22, 0);
      push(0, 8'h08, 0);
      push(0, 8'h09, 0);
      push(1, 8'h09, 8'hFF);
      run_start(8'h20);
      exec(n);
      chk("ht_result", {24'b0, result}, 32'hFF);
      chk("ht_halted", {31'b0, halted}, 32'd1);
      chk("ht_busy", {31'b0, busy}, 32'd0);
      chk("ht_req", {31'b0, bus.mem_req}, 32'd0);
      chk("ht_pc", {24'b0, pc}, 32'h20);
      idle(2);
      chk("ht_hold", {31'b0, halted}, 32'd1);
      run_start(8'h00);
      chk("ht_resume_req", {31'b0, bus.mem_req}, 32'd1);
      chk("ht_resume_addr", {24'b0, bus.mem_addr}, 32'h00);
      chk("ht_resume_pc", {24'b0, pc}, 32'h00);
      do_reset();

      // wait states and address wrap
      clr_mem();
      mem[8'hFE] = 8'h10;
      mem[8'hFF] = 8'h11;
      mem[8'h00] = 8'h40;
      mem[8'h01] = 8'h10;
      mem[8'h02] = 8'h11;
      mem[8'h03] = 8'h00;
      mem[8'h10] = 8'h02;
      mem[8'h11] = 8'h05;
      dly = 3;
      push(0, 8'hFE, 0);
      push(0, 8'hFF, 0);
      push(0, 8'h00, 0);
      push(0, 8'h10, 0);
      push(0, 8'h11, 0);
      push(1, 8'h11, 8'h03);
      run_start(8'hFE);
      exec(n);
      chk("ws_cycles", 32'(n), 32'(7 + 6 * 3));
      chk("ws_pc", {24'b0, pc}, 32'h01);
      chk("ws_result", {24'b0, result}, 32'h03);
      chk("ws_sb_left", 32'(q.size()), 32'd0);
`ifdef SUBNEG_STEP_EN
      run_start(8'h00);
`endif
      push(0, 8'h01, 0);
      push(0, 8'h02, 0);
      push(0, 8'h03, 0);
      push(0, 8'h10, 0);
      push(0, 8'h11, 0);
      push(1, 8'h11, 8'h01);
      k = 0;
      while (!(bus.mem_req && bus.mem_we) && k < 300) begin
         step(w);
         k++;
      end
      chk("wr_pending", {31'b0, bus.mem_req & bus.mem_we}, 32'd1);
      chk("wr_pend_data", {24'b0, bus.mem_wdata}, 32'h01);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req", {31'b0, bus.mem_req}, 32'd0);
      chk("async_pc", {24'b0, pc}, 32'd0);
      chk("no_partial_wr", {24'b0, mem[8'h11]}, 32'h03);
      chk("async_sb_left", 32'(q.size()), 32'd1);
      q.delete();
      pend  = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_busy", {31'b0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
